// File: rtl/complex_mag_stream_mul_arb.sv
// complex_mag_stream_mul_arb: round-robin sharing of one pipelined multiplier among NREQ requesters
module complex_mag_stream_mul_arb #(
   parameter int NREQ    = 4,
   parameter int A_W     = 44,
   parameter int B_W     = 6,
   parameter int P_W     = 50,
   parameter int MUL_LAT = 4,
   parameter int ID_W    = $clog2(NREQ),
   parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*A_W-1:0] req_a,
   input  logic [NREQ*B_W-1:0] req_b,
   output logic [NREQ-1:0]     rsp_valid,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [P_W-1:0]      rsp_data,
   output logic                mul_ce,
   output logic [A_W-1:0]      mul_din0,
   output logic [B_W-1:0]      mul_din1,
   input  logic [P_W-1:0]      mul_dout,
   output logic [CNT_W-1:0]    inflight
);
   logic [MUL_LAT-1:0] tag_v;
   logic [ID_W-1:0]    tag_id [MUL_LAT];
   logic [ID_W-1:0]    rr_ptr, g, idx;
   logic               grant, advance;

   // an unaccepted head result freezes the whole pipeline, multiplier included
   always_comb begin
      advance   = !(tag_v[MUL_LAT-1] && !rsp_ready[tag_id[MUL_LAT-1]]);
      mul_ce    = advance;
      rsp_valid = tag_v[MUL_LAT-1] ? NREQ'(1) << tag_id[MUL_LAT-1] : '0;
      rsp_data  = mul_dout;
   end

   // first valid requester at or after rr_ptr wins; nothing is granted while stalled or in reset
   always_comb begin
      grant = 1'b0;
      g     = '0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(rr_ptr) + k) % NREQ);
         if (req_valid[idx]) begin
            grant = advance && ap_rst_n;
            g     = idx;
         end
      end
      req_ready = grant ? NREQ'(1) << g : '0;
      mul_din0  = grant ? req_a[g*A_W +: A_W] : '0;
      mul_din1  = grant ? req_b[g*B_W +: B_W] : '0;
   end

   // tag pipeline, round-robin pointer and occupancy count all hold on a stall
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         tag_v    <= '0;
         rr_ptr   <= '0;
         inflight <= '0;
         for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
      end else if (advance) begin
         tag_v     <= {tag_v[MUL_LAT-2:0], grant};
         tag_id[0] <= g;
         for (int i = 1; i < MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
         if (grant) rr_ptr <= (g == ID_W'(NREQ - 1)) ? '0 : g + ID_W'(1);
         if (grant != tag_v[MUL_LAT-1]) inflight <= grant ? inflight + CNT_W'(1) : inflight - CNT_W'(1);
      end
   end
endmodule
